// File: rtl/priority_encoder_8_to_3.sv
// Registered 8-to-3 priority encoder: reports the index of the highest set
// request bit one cycle after sampling, with valid meaning "any bit set".
module priority_encoder_8_to_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid
);

    logic [2:0] out_d;
    logic [2:0] out_q;
    logic       valid_d;
    logic       valid_q;

    // Ascending scan so the highest set bit is the last one written and wins.
    always_comb begin
        // NOTE: defaults first so every path assigns out_d/valid_d and no latch is inferred.
        out_d   = 3'd0;
        valid_d = |in;
        for (int i = 0; i < 8; i++) begin
            if (in[i]) begin
                out_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the statement order.
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_8_to_3.sv
// Self-checking bench for priority_encoder_8_to_3: table-driven vectors fed
// through an expected-result queue, plus reset and latency sequences.
module tb_priority_encoder_8_to_3;

    typedef struct {
        logic [7:0] in;
        logic [2:0] exp_out;
        logic       exp_valid;
    } vec_t;

    typedef struct {
        logic [2:0] out;
        logic       valid;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_s;
    logic [2:0] out_s;
    logic       valid_s;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    priority_encoder_8_to_3 dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in_s),
        .out  (out_s),
        .valid(valid_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: explicit descending priority chain.
    function automatic logic [2:0] model_out(input logic [7:0] v);
        if (v[7]) return 3'd7;
        else if (v[6]) return 3'd6;
        else if (v[5]) return 3'd5;
        else if (v[4]) return 3'd4;
        else if (v[3]) return 3'd3;
        else if (v[2]) return 3'd2;
        else if (v[1]) return 3'd1;
        else return 3'd0;
    endfunction

    // Drive one vector, queue its expectation, compare one edge later.
    task automatic apply(input logic [7:0] v, input logic [2:0] eo, input logic ev, input string tag);
        exp_t e;
        e.out   = eo;
        e.valid = ev;
        e.tag   = tag;
        sb.push_back(e);
        in_s = v;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got out=%0d valid=%0b", tag, out_s, valid_s);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_out"}, 8'(out_s), 8'(e.out));
            check({e.tag, "_valid"}, 8'(valid_s), 8'(e.valid));
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0] r;

        vecs = '{
            '{8'h01, 3'd0, 1'b1}, '{8'h02, 3'd1, 1'b1}, '{8'h04, 3'd2, 1'b1},
            '{8'h08, 3'd3, 1'b1}, '{8'h10, 3'd4, 1'b1}, '{8'h20, 3'd5, 1'b1},
            '{8'h40, 3'd6, 1'b1}, '{8'h80, 3'd7, 1'b1},
            '{8'h03, 3'd1, 1'b1}, '{8'h07, 3'd2, 1'b1}, '{8'h0F, 3'd3, 1'b1},
            '{8'h1F, 3'd4, 1'b1}, '{8'h3F, 3'd5, 1'b1}, '{8'h7F, 3'd6, 1'b1},
            '{8'hFF, 3'd7, 1'b1},
            '{8'h00, 3'd0, 1'b0}, '{8'h81, 3'd7, 1'b1}, '{8'h05, 3'd2, 1'b1},
            '{8'h01, 3'd0, 1'b1}, '{8'h00, 3'd0, 1'b0}
        };

        // Reset held with all requests set: outputs stay cleared across edges.
        rst  = 1'b1;
        in_s = 8'hFF;
        #1;
        check("reset_immediate_out", 8'(out_s), 8'd0);
        check("reset_immediate_valid", 8'(valid_s), 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold_out", 8'(out_s), 8'd0);
            check("reset_hold_valid", 8'(valid_s), 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_pre_edge_valid", 8'(valid_s), 8'd0);
        apply(8'hFF, 3'd7, 1'b1, "reset_release");

        // Table sweep: one-hot, thermometer, zero and sparse patterns.
        foreach (vecs[i]) begin
            apply(vecs[i].in, vecs[i].exp_out, vecs[i].exp_valid, $sformatf("vec%0d_%02h", i, vecs[i].in));
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 40; i++) begin
            r = 8'($urandom_range(0, 255));
            apply(r, model_out(r), r != 8'h00, $sformatf("rand%0d_%02h", i, r));
        end

        // Latency: a change between edges must not reach the outputs early.
        apply(8'h01, 3'd0, 1'b1, "latency_first");
        @(negedge clk);
        in_s = 8'h80;
        #1;
        check("latency_between_edges_out", 8'(out_s), 8'd0);
        check("latency_between_edges_valid", 8'(valid_s), 8'd1);
        apply(8'h80, 3'd7, 1'b1, "latency_next_edge");

        // Async reset mid-stream, asserted between edges.
        apply(8'h40, 3'd6, 1'b1, "stream_40");
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_out", 8'(out_s), 8'd0);
        check("async_reset_valid", 8'(valid_s), 8'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("async_reset_edge_out", 8'(out_s), 8'd0);
        check("async_reset_edge_valid", 8'(valid_s), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(8'h40, 3'd6, 1'b1, "async_reset_release");

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
